// File: rtl/disc_sqrt_seq.sv
// Sequential discriminant d = b*b - 4*c with a bit-serial restoring square root of |d|.
// One sqrt iteration per cycle; the result is handed off through a valid/ready handshake.
module disc_sqrt_seq #(
   parameter int W = 8
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [W-1:0]   b_in,
   input  logic [W-1:0]   c_in,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [W-1:0]   b_out,
   output logic [2*W:0]   disc,
   output logic           disc_neg,
   output logic [W-1:0]   root_mag,
   output logic           exact
);

   localparam int CW = (W > 1) ? $clog2(W) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      OUT  = 2'd2
   } state_t;

   state_t            state_q;
   logic              in_ready_q;
   logic              out_valid_q;
   logic [W-1:0]      b_q;
   logic [2*W:0]      disc_q;
   logic              disc_neg_q;
   logic [W-1:0]      root_mag_q;
   logic              exact_q;
   logic [2*W-1:0]    rad_q;
   logic [W-1:0]      root_q;
   logic [W+1:0]      rem_q;
   logic [CW-1:0]     cnt_q;

   logic signed [2*W:0] b_ext;
   logic signed [2*W:0] c4_ext;
   logic signed [2*W:0] d_full;
   logic [2*W-1:0]      d_abs;
   logic [W+3:0]        rem_shift;
   logic [W+3:0]        trial;
   logic                take;
   logic [W+1:0]        rem_d;
   logic [W-1:0]        root_d;

   // Discriminant is exact in 2W+1 bits, so |d| always fits the 2W-bit radicand
   always_comb begin
      b_ext  = {{(W+1){b_in[W-1]}}, b_in};
      c4_ext = {{(W-1){c_in[W-1]}}, c_in, 2'b00};
      d_full = b_ext * b_ext - c4_ext;
      d_abs  = d_full[2*W] ? (2*W)'(-d_full) : (2*W)'(d_full);
   end

   always_comb begin
      rem_shift = {rem_q, rad_q[2*W-1 -: 2]};
      trial     = {2'b00, root_q, 2'b01};
      take      = (rem_shift >= trial);
      rem_d     = take ? (W+2)'(rem_shift - trial) : (W+2)'(rem_shift);
      root_d    = {root_q[W-2:0], take};
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         b_q         <= '0;
         disc_q      <= '0;
         disc_neg_q  <= 1'b0;
         root_mag_q  <= '0;
         exact_q     <= 1'b0;
         rad_q       <= '0;
         root_q      <= '0;
         rem_q       <= '0;
         cnt_q       <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  b_q        <= b_in;
                  disc_q     <= d_full;
                  disc_neg_q <= d_full[2*W];
                  rad_q      <= d_abs;
                  root_q     <= '0;
                  rem_q      <= '0;
                  cnt_q      <= CW'(W-1);
                  in_ready_q <= 1'b0;
                  state_q    <= CALC;
               end
            end
            CALC: begin
               rad_q  <= {rad_q[2*W-3:0], 2'b00};
               rem_q  <= rem_d;
               root_q <= root_d;
               if (cnt_q == '0) begin
                  root_mag_q  <= root_d;
                  exact_q     <= (rem_d == '0);
                  out_valid_q <= 1'b1;
                  state_q     <= OUT;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            OUT: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state_q     <= IDLE;
               end
            end
            default: begin
               state_q     <= IDLE;
               in_ready_q  <= 1'b1;
               out_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign b_out     = b_q;
   assign disc      = disc_q;
   assign disc_neg  = disc_neg_q;
   assign root_mag  = root_mag_q;
   assign exact     = exact_q;

endmodule

// File: doc/disc_sqrt_seq.md
Name: disc_sqrt_seq

Overview:
- Sequential discriminant-and-square-root front stage for the quadratic root path.
- Accepts one coefficient pair (b, c) for x^2 + b*x + c = 0 and computes d = b*b - 4*c, sign(d) and floor(sqrt(|d|)) with a bit-serial restoring square root.
- Hands the result, plus b passed through, to the downstream root-assembly stage via valid/ready.
- Replaces the unbounded search-loop square root with a fixed-latency engine.

Parameters:
W  8  coefficient width; sqrt result width; number of sqrt iterations (one per cycle)

Ports:
clk        in   1      rising-edge clock
rst_n      in   1      synchronous active-low reset
in_valid   in   1      b_in/c_in valid
in_ready   out  1      stage can accept a pair
b_in       in   W      signed coefficient b
c_in       in   W      signed coefficient c
out_valid  out  1      result valid
out_ready  in   1      downstream accepts result
b_out      out  W      signed, captured b
disc       out  2W+1   signed d = b*b - 4*c
disc_neg   out  1      1 when d < 0 (complex roots); 0 when d >= 0
root_mag   out  W      unsigned floor(sqrt(|d|))
exact      out  1      1 when root_mag*root_mag == |d|

Behaviour:
- Reset (rst_n low at a clk edge): state IDLE; in_ready=1 after the edge; out_valid, b_out, disc, disc_neg, root_mag, exact all 0. Any in-flight operation is discarded silently.
- FSM has three states:
  - IDLE: in_ready=1, out_valid=0. On in_valid&&in_ready at an edge:
    - capture b_in and c_in;
    - compute d in 2W+1 signed bits: b sign-extended and squared, minus 4*c sign-extended, no truncation;
    - load radicand = |d| into a 2W-bit unsigned register;
    - clear the partial root and remainder; set iteration counter = W-1; go to CALC.
  - CALC: in_ready=0, out_valid=0. Each edge runs one restoring iteration on the next two radicand bits, MSB pair first:
    - rem' = (rem<<2)|pair; trial = (root<<2)|1;
    - if rem' >= trial: rem = rem' - trial, root = (root<<1)|1; else rem = rem', root = root<<1.
    - After the iteration with counter == 0, go to OUT.
  - OUT: out_valid=1; outputs hold constant while out_ready=0. On out_valid&&out_ready at an edge, go to IDLE.
- Latency: out_valid is high in the cycle starting W clock edges after the accepting edge (8 for W=8).
- Throughput: at most one operation per W+2 cycles. No input/output overlap, no skid buffer.
- exact = (final remainder == 0).
- disc_neg = sign bit of d. d == 0 gives disc_neg=0, root_mag=0, exact=1.
- Ranges for W=8:
  - |d| max 16896 (b=-128, c=-128), fits the 2W-bit radicand;
  - root_mag max 129, fits W bits.
  - For any W, |d| < 2^(2W), so no overflow is possible.
- in_valid while in_ready=0 is ignored. Upstream holds its data until the handshake.
- Output registers change only on the IDLE->CALC capture (b_out, disc, disc_neg) or at CALC completion (root_mag, exact). Stale values while out_valid=0 are don't-care, except zeros after reset.
- Reset asserted in the same cycle as a handshake: reset wins, the pair is not captured.

Test Plan:
1. b=-3, c=2, out_ready=1 -> out_valid 8 cycles after accept; disc=1, disc_neg=0, root_mag=1, exact=1, b_out=-3; in_ready back to 1 the cycle after the output handshake.
2. b=2, c=5 -> disc=-16, disc_neg=1, root_mag=4, exact=1.
3. b=-128, c=-128 -> disc=16896, disc_neg=0, root_mag=129, exact=0. Then b=3, c=1 -> disc=5, root_mag=2, exact=0.
4. b=4, c=4 -> disc=0, disc_neg=0, root_mag=0, exact=1. Also b=0, c=0 -> same.
5. Backpressure on b=5, c=6: hold out_ready=0 for 5 cycles in OUT -> out_valid stays 1, all outputs stable (disc=1, root_mag=1), in_ready=0, and a new in_valid pulse is ignored. Release -> single handshake, then IDLE.
6. Reset mid-CALC: accept b=7, c=1, drop rst_n for one edge 4 cycles later -> next cycle in_ready=1, out_valid=0, outputs 0. Then b=7, c=1 -> disc=45, root_mag=6, exact=0 after exactly 8 cycles.
